// File: rtl/multi_divider_pkg.sv
// Shared clock-divider constants used by every clock-generation block.
package multi_divider_pkg;
  localparam int unsigned MD_N_CH    = 4;
  localparam int unsigned MD_W       = 32;
  localparam int unsigned MD_DEF_DIV = 20;
endpackage

// File: rtl/div_channel.sv
// One divider channel: phase counter, active/shadow divisor, registered clk_out and tick.
module div_channel
  import multi_divider_pkg::*;
#(
  parameter int unsigned W       = MD_W,
  parameter logic [W-1:0] DEF_DIV = W'(MD_DEF_DIV)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_sync,
  input  logic         i_load,
  input  logic [W-1:0] i_div,
  output logic         o_clk_out,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_active;
  logic [W-1:0] r_shadow;
  logic         r_run;
  logic         r_clk_out;
  logic         r_tick;

  logic         w_boundary;
  logic [W-1:0] w_div;
  logic [W-1:0] w_k;
  logic [W-1:0] w_half;

  // A new period starts on enable, sync, a stopped divisor, or wrap at D-1.
  always_comb begin
    w_boundary = 1'b0;
    w_div      = r_active;
    w_k        = '0;
    w_half     = '0;
    w_boundary = !r_run || i_sync || (r_active == '0) || (r_cnt == r_active - W'(1));
    w_div      = w_boundary ? r_shadow : r_active;
    w_k        = w_boundary ? '0 : r_cnt + W'(1);
    w_half     = (w_div >> 1) + W'(w_div[0]);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_active  <= DEF_DIV;
      r_shadow  <= DEF_DIV;
      r_run     <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      // The boundary above already sampled the old shadow, so a coincident load waits one period.
      if (i_load) r_shadow <= i_div;
      if (!i_en) begin
        r_cnt     <= '0;
        r_run     <= 1'b0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        r_run    <= 1'b1;
        r_active <= w_div;
        if (w_div == '0) begin
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
          r_tick    <= 1'b0;
        end else begin
          r_cnt     <= w_k;
          r_clk_out <= (w_k < w_half);
          r_tick    <= (w_k == '0);
        end
      end
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/multi_divider.sv
// N_CH independent programmable clock dividers sharing div_in and a common sync strobe.
module multi_divider
  import multi_divider_pkg::*;
#(
  parameter int unsigned N_CH    = MD_N_CH,
  parameter int unsigned W       = MD_W,
  parameter int unsigned DEF_DIV = MD_DEF_DIV
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  input  logic [N_CH-1:0] load,
  input  logic [W-1:0]    div_in,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    div_channel #(
      .W       (W),
      .DEF_DIV (W'(DEF_DIV))
    ) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
      .i_en      (en[g]),
      .i_sync    (sync),
      .i_load    (load[g]),
      .i_div     (div_in),
      .o_clk_out (clk_out[g]),
      .o_tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_divider.sv
// Bench for multi_divider: per-edge behavioural model plus directed literal scenarios.
module tb_multi_divider;
  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  localparam int unsigned DEFD = 20;

  logic         clk_in;
  logic         rst;
  logic [N-1:0] en;
  logic         sync;
  logic [N-1:0] load;
  logic [W-1:0] div_in;
  logic [N-1:0] clk_out;
  logic [N-1:0] tick;

  int errors = 0;
  int checks = 0;

  multi_divider #(.N_CH(N), .W(W), .DEF_DIV(DEFD)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .load    (load),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Model: k counts enabled edges since the period start, d is the active divisor.
  longint unsigned m_k  [N];
  longint unsigned m_d  [N];
  longint unsigned m_sh [N];
  bit              m_run[N];
  logic [N-1:0]    exp_clk;
  logic [N-1:0]    exp_tick;
  longint unsigned prev_sh;

  always @(posedge clk_in or posedge rst) begin
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_run[c] = 0; m_k[c] = 0; m_d[c] = DEFD; m_sh[c] = DEFD;
        exp_clk[c] = 1'b0; exp_tick[c] = 1'b0;
      end else begin
        prev_sh = m_sh[c];
        if (load[c]) m_sh[c] = longint'(div_in);
        if (!en[c]) begin
          m_run[c] = 0; m_k[c] = 0;
          exp_clk[c] = 1'b0; exp_tick[c] = 1'b0;
        end else begin
          if (!m_run[c] || sync || m_d[c] == 0 || m_k[c] + 1 == m_d[c]) begin
            m_d[c] = prev_sh;
            m_k[c] = 0;
          end else begin
            m_k[c] = m_k[c] + 1;
          end
          m_run[c] = 1;
          exp_clk[c]  = (m_d[c] != 0) && (m_k[c] < (m_d[c] + 1) / 2);
          exp_tick[c] = (m_d[c] != 0) && (m_k[c] == 0);
        end
      end
    end
  end

  always @(negedge clk_in) begin
    for (int c = 0; c < N; c++) begin
      checks++;
      if (clk_out[c] !== exp_clk[c] || tick[c] !== exp_tick[c]) begin
        errors++;
        $display("FAIL model_cmp ch%0d t=%0t: clk_out=%b tick=%b expected %b %b",
                 c, $time, clk_out[c], tick[c], exp_clk[c], exp_tick[c]);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp_v);
    end
  endtask

  task automatic cyc(input logic s, input logic [N-1:0] l, input logic [W-1:0] d);
    sync = s; load = l; div_in = d;
    @(posedge clk_in);
    @(negedge clk_in);
    sync = 1'b0; load = '0;
  endtask

  // Disable a channel and load its shadow so the divisor applies on re-enable.
  task automatic prep(input int ch, input logic [W-1:0] d);
    en[ch] = 1'b0;
    cyc(1'b0, N'(1) << ch, d);
  endtask

  logic [39:0] cap_a, cap_b;

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; load = '0; div_in = '0;
    @(negedge clk_in);
    chk("reset_clk_out", longint'(clk_out), 0);
    chk("reset_tick", longint'(tick), 0);
    #1 rst = 1'b0;
    @(negedge clk_in);

    // D=4 from enable
    prep(0, 4); en[0] = 1'b1; cap_a = '0; cap_b = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0); cap_a[i] = clk_out[0]; cap_b[i] = tick[0];
    end
    chk("d4_clk", longint'(cap_a), 'h33);
    chk("d4_tick", longint'(cap_b), 'h11);

    // D=5 odd: 3 high, 2 low
    prep(0, 5); en[0] = 1'b1; cap_a = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, '0); cap_a[i] = clk_out[0];
    end
    chk("d5_clk", longint'(cap_a), 'h0E7);

    // D=1 and D=0
    prep(0, 1); en[0] = 1'b1; cap_a = '0; cap_b = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0); cap_a[i] = clk_out[0]; cap_b[i] = tick[0];
    end
    chk("d1_clk", longint'(cap_a), 'hF);
    chk("d1_tick", longint'(cap_b), 'hF);
    prep(0, 0); en[0] = 1'b1; cap_a = '0; cap_b = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0); cap_a[i] = clk_out[0]; cap_b[i] = tick[0];
    end
    chk("d0_clk", longint'(cap_a), 0);
    chk("d0_tick", longint'(cap_b), 0);

    // D=6, load 2 at k=2: new divisor from k=6
    prep(1, 6); en[1] = 1'b1; cap_a = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i == 2) ? N'(2) : N'(0), 2); cap_a[i] = clk_out[1];
    end
    chk("shadow_load_clk", longint'(cap_a), 'h147);

    // D=3 and D=7 at different phases, then sync
    prep(2, 3); prep(3, 7);
    en[2] = 1'b1; cyc(1'b0, '0, '0); cyc(1'b0, '0, '0);
    en[3] = 1'b1; cyc(1'b0, '0, '0); cyc(1'b0, '0, '0); cyc(1'b0, '0, '0);
    cyc(1'b1, '0, '0);
    chk("sync_tick", longint'(tick[3:2]), 3);
    chk("sync_clk", longint'(clk_out[3:2]), 3);
    cap_a = '0; cap_b = '0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, '0, '0); cap_a[i] = tick[2]; cap_b[i] = tick[3];
    end
    chk("post_sync_tick_d3", longint'(cap_a), 'h24);
    chk("post_sync_tick_d7", longint'(cap_b), 'h40);

    // Enable dropped at k=1 for 3 edges
    prep(0, 4); en[0] = 1'b1;
    cyc(1'b0, '0, '0); cyc(1'b0, '0, '0);
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0);
      chk("disabled_out", longint'({clk_out[0], tick[0]}), 0);
    end
    en[0] = 1'b1; cyc(1'b0, '0, '0);
    chk("reenable_out", longint'({clk_out[0], tick[0]}), 3);

    // Async reset mid-period discards the period and a pending shadow
    prep(1, 1); en = '1;
    cyc(1'b0, '0, '0); cyc(1'b0, '0, '0);
    cyc(1'b0, N'(1), 3);
    chk("pre_rst_d1_tick", longint'(tick[1]), 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_out", longint'({clk_out, tick}), 0);
    @(negedge clk_in);
    #1 rst = 1'b0;
    cap_a = '0; cap_b = '0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, '0, '0); cap_a[i] = clk_out[0]; cap_b[i] = tick[0];
    end
    chk("post_rst_def_clk", longint'(cap_a), 'h3FF003FF);
    chk("post_rst_def_tick", longint'(cap_b), 'h100001);

    // Randomised traffic against the model
    for (int it = 0; it < 3000; it++) begin
      logic [N-1:0] l;
      logic [W-1:0] d;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
        l[c] = ($urandom_range(0, 7) == 0);
      end
      d = ($urandom_range(0, 63) == 0) ? '1 : W'($urandom_range(0, 9));
      cyc($urandom_range(0, 31) == 0, l, d);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/multi_divider.md
MULTI_DIVIDER -- requirements
Module: multi_divider

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divider channels.
REQ-002 SHALL have parameter W, default 32, divisor/counter width in bits.
REQ-003 SHALL have parameter DEF_DIV, default 20, divisor loaded into every channel at reset.
REQ-004 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port en  input  N_CH  per-channel run enable.
REQ-007 SHALL have port sync  input  1  one-cycle strobe; restarts the phase of all enabled channels together.
REQ-008 SHALL have port load  input  N_CH  per-channel strobe; captures div_in into that channel's shadow divisor.
REQ-009 SHALL have port div_in  input  W  divisor value shared by all channels, qualified by load.
REQ-010 SHALL have port clk_out  output  N_CH  per-channel divided clock, registered.
REQ-011 SHALL have port tick  output  N_CH  per-channel one-cycle pulse at the start of each period, registered.

Function
REQ-012 SHALL number, per channel, rising edges with en=1 as k=0,1,2,... from enable or sync, with D the active divisor.
REQ-013 SHALL drive, after edge k with D>=2: clk_out=1 iff (k mod D) < ceil(D/2); tick=1 iff (k mod D)==0.
REQ-014 SHALL produce a high phase of ceil(D/2) cycles and a low phase of floor(D/2) cycles for odd D.
REQ-015 SHALL, for D=1, hold clk_out=1 and assert tick on every enabled edge.
REQ-016 SHALL treat D=0 as stopped: clk_out=0, tick=0, phase held at 0.
REQ-017 SHALL, on an edge with en[i]=0, clear channel i's phase counter, clk_out[i] and tick[i]; re-enable restarts at k=0.
REQ-018 SHALL, on an edge with sync=1, force every enabled channel to k=0 on that edge: tick=1, clk_out=1 when D>=1.
REQ-019 SHALL, on load[i]=1, write div_in to shadow[i]; the active divisor SHALL be updated from the shadow only at a period boundary, i.e. the edge where k mod D returns to 0, or at sync or enable.
REQ-020 SHALL apply a shadow written while a channel is disabled or stopped (D=0) at the next edge with en=1.
REQ-021 SHALL, when load and a period boundary coincide on the same edge, start the new period with the old shadow; the newly loaded value SHALL take effect at the following boundary.
REQ-022 SHALL give sync priority over period wrap, and en=0 priority over sync.
REQ-023 SHALL compute counters at width W without overflow for any D up to 2^W-1, with wrap at D-1 only.
REQ-024 SHALL keep channels fully independent apart from the shared div_in and sync inputs.

Reset
REQ-025 SHALL, while rst=1, asynchronously force clk_out=0, tick=0, phase counters=0, and active and shadow divisors=DEF_DIV.
REQ-026 SHALL resume per REQ-013 from k=0 on the first edge after rst deasserts with en=1.
REQ-027 SHALL make rst asserted mid-period discard the current period and any pending shadow value.

Structure
REQ-028 SHALL place DEF_DIV and the default W and N_CH in the shared clock-divider constants package or header, used by all clock-generation blocks.
REQ-029 SHALL implement one channel as sub-module div_channel, instantiated N_CH times via a generate loop.

Verification
REQ-030 SHALL cover: D=4, en[0] rises -> clk_out[0] after edges 0..7 = 1,1,0,0,1,1,0,0; tick[0]=1 at edges 0 and 4.
REQ-031 SHALL cover: D=5 -> clk_out = 1,1,1,0,0 repeating; D=1 -> clk_out constant 1 with tick every edge; D=0 -> both 0.
REQ-032 SHALL cover: D=6 running, load div_in=2 at k=2 -> remaining period keeps 6; from k=6, period=2 (clk_out 1,0).
REQ-033 SHALL cover: channels with D=3 and D=7 at different phases, pulse sync -> both tick=1 on the same edge, then independent periods.
REQ-034 SHALL cover: rst pulsed asynchronously mid-period between edges -> outputs 0 immediately; after release, period is DEF_DIV=20 (10 high, 10 low).
REQ-035 SHALL cover: en dropped at k=1 and raised 3 cycles later -> outputs 0 while disabled; restart at k=0 with tick=1.
